calc_op_sequencer: RTL and testbench

Sequences the calculator datapath from the front-panel buttons. Conditions the raw add/sub/mult/sqr/toggle-sign buttons, arbitrates them into one operation at a time and drives the operation select, multiplier start, add/subtract mode and sign mode. It waits for the multiplier handshake where needed, then issues a one-cycle load strobe to the result/sign/valid registers. It sits between the button pins and the adder, multiplier and result registers in the top level.

---
 rtl/calc_pkg.sv | 46 ++++
 rtl/calc_op_sequencer_if.sv | 30 +++
 rtl/btn_conditioner.sv | 71 +++++++
 rtl/calc_op_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator operation sequencer.
// The op_e encoding is also the datapath mux encoding: bit 1 selects the
// multiplier result.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MULT = 2'b10,
    OP_SQR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    LOAD  = 2'b11
  } seq_state_e;

  // Operations that go through the multiplier handshake.
  function automatic logic op_uses_mult(input op_e op);
    return op[1];
  endfunction

  // Fixed priority add > sub > mult > sqr.
  // Request vector bit order: [0]=add [1]=sub [2]=mult [3]=sqr.
  function automatic op_e op_priority(input logic [3:0] req);
    op_e op;
    if (req[0]) begin
      op = OP_ADD;
    end else if (req[1]) begin
      op = OP_SUB;
    end else if (req[2]) begin
      op = OP_MULT;
    end else begin
      op = OP_SQR;
    end
    return op;
  endfunction

  // True when more than one request bit is set in the same cycle.
  function automatic logic op_multi_req(input logic [3:0] req);
    return |(req & (req - 4'd1));
  endfunction

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Button / datapath-control bundle of the calculator operation sequencer.
// master: the sequencer itself. slave: the board / datapath side.
interface calc_op_sequencer_if;

  logic       btn_add;
  logic       btn_sub;
  logic       btn_mult;
  logic       btn_sqr;
  logic       btn_sgd;
  logic       mult_done;
  logic [1:0] sel;
  logic       enter;
  logic       add_sub;
  logic       sgd;
  logic       load;
  logic       busy;
  logic       timeout;
  logic       overflow;

  modport master (
    input  btn_add, btn_sub, btn_mult, btn_sqr, btn_sgd, mult_done,
    output sel, enter, add_sub, sgd, load, busy, timeout, overflow
  );

  modport slave (
    output btn_add, btn_sub, btn_mult, btn_sqr, btn_sgd, mult_done,
    input  sel, enter, add_sub, sgd, load, busy, timeout, overflow
  );

endinterface

// File: rtl/btn_conditioner.sv
// Raw button conditioning: 2-flop synchronizer, optional debounce, and a
// rising-edge detector producing a one-cycle request pulse.
// Optional feature macro: OPSEQ_DEBOUNCE_EN (debounce filter stage).
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_level;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef OPSEQ_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] r_db_cnt;
  logic            r_db_level;

  // Accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
    end else if (r_sync2 == r_db_level) begin
      r_db_cnt   <= '0;
      r_db_level <= r_db_level;
    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db_cnt   <= '0;
      r_db_level <= r_sync2;
    end else begin
      r_db_cnt   <= r_db_cnt + DB_W'(1);
      r_db_level <= r_db_level;
    end
  end

  assign w_level = r_db_level;
`else
  // Debounce disabled: the parameter is intentionally left unused.
  logic w_unused_db;
  assign w_unused_db = (DEBOUNCE_CYCLES > 0);
  assign w_level     = r_sync2;
`endif

  // Remember the previous level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_pulse = w_level & ~r_prev;

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator operation sequencer: conditions the front-panel buttons,
// arbitrates one operation at a time (with a one-deep pending slot), drives
// the datapath select/start/mode lines and strobes the result load.
// Optional feature macro: OPSEQ_DEBOUNCE_EN (enables the debounce stage
// inside each btn_conditioner; DEBOUNCE_CYCLES is only used then).
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input logic                 clk,
  input logic                 rst_n,
  calc_op_sequencer_if.master bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Conditioned request pulses.
  logic       w_req_add;
  logic       w_req_sub;
  logic       w_req_mult;
  logic       w_req_sqr;
  logic       w_req_sgd;
  logic [3:0] w_req_ops;
  logic       w_new_req;
  op_e        w_new_op;

  // State and registered outputs.
  seq_state_e       r_state;
  op_e              r_sel;
  logic             r_add_sub;
  logic             r_enter;
  logic             r_load;
  logic             r_busy;
  logic             r_sgd;
  logic             r_ovf;
  logic             r_pend_valid;
  op_e              r_pend_op;
  logic [CNT_W-1:0] r_cnt;

  // Next-state values.
  seq_state_e       w_state_nxt;
  op_e              w_sel_nxt;
  logic             w_sgd_nxt;
  logic             w_ovf_nxt;
  logic             w_pend_valid_nxt;
  op_e              w_pend_op_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_timeout;
  logic             w_take_pend;
  logic             w_new_direct;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_add (
    .clk(clk), .rst_n(rst_n), .i_btn(bus.btn_add), .o_pulse(w_req_add));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_sub (
    .clk(clk), .rst_n(rst_n), .i_btn(bus.btn_sub), .o_pulse(w_req_sub));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_mult (
    .clk(clk), .rst_n(rst_n), .i_btn(bus.btn_mult), .o_pulse(w_req_mult));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_sqr (
    .clk(clk), .rst_n(rst_n), .i_btn(bus.btn_sqr), .o_pulse(w_req_sqr));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_sgd (
    .clk(clk), .rst_n(rst_n), .i_btn(bus.btn_sgd), .o_pulse(w_req_sgd));

  assign w_req_ops = {w_req_sqr, w_req_mult, w_req_sub, w_req_add};
  assign w_new_req = |w_req_ops;
  assign w_new_op  = op_priority(w_req_ops);

  // Next-state, pending-slot, sign-toggle and drop decisions.
  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_sgd_nxt        = r_sgd;
    w_ovf_nxt        = op_multi_req(w_req_ops);
    w_pend_valid_nxt = r_pend_valid;
    w_pend_op_nxt    = r_pend_op;
    w_cnt_nxt        = r_cnt;
    w_timeout        = 1'b0;
    w_take_pend      = 1'b0;
    w_new_direct     = 1'b0;

    case (r_state)
      IDLE: begin
        // A waiting pending op goes first; a new pulse then falls into pending.
        if (r_pend_valid) begin
          w_state_nxt = ISSUE;
          w_sel_nxt   = r_pend_op;
          w_take_pend = 1'b1;
        end else if (w_new_req) begin
          w_state_nxt  = ISSUE;
          w_sel_nxt    = w_new_op;
          w_new_direct = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (op_uses_mult(r_sel)) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = LOAD;
        end
      end
      WAIT: begin
        if (bus.mult_done) begin
          w_state_nxt = LOAD;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = IDLE;
          w_timeout   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      LOAD: begin
        if (r_pend_valid) begin
          w_state_nxt = ISSUE;
          w_sel_nxt   = r_pend_op;
          w_take_pend = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_take_pend) begin
      w_pend_valid_nxt = 1'b0;
    end else begin
      w_pend_valid_nxt = r_pend_valid;
    end

    // A request not launched directly goes to pending if the slot is (or is
    // becoming) free, otherwise it is dropped.
    if (w_new_req && !w_new_direct) begin
      if (!r_pend_valid || w_take_pend) begin
        w_pend_valid_nxt = 1'b1;
        w_pend_op_nxt    = w_new_op;
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end else begin
      w_pend_op_nxt = r_pend_op;
    end

    // Sign toggles only when idle; otherwise the press is dropped.
    if (w_req_sgd) begin
      if (r_state == IDLE) begin
        w_sgd_nxt = ~r_sgd;
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end else begin
      w_sgd_nxt = r_sgd;
    end
  end

  // State, pending slot, timeout counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sel        <= OP_ADD;
      r_add_sub    <= 1'b0;
      r_enter      <= 1'b0;
      r_load       <= 1'b0;
      r_busy       <= 1'b0;
      r_sgd        <= 1'b0;
      r_ovf        <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_op    <= OP_ADD;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_add_sub    <= (w_sel_nxt == OP_SUB);
      r_enter      <= (w_state_nxt == ISSUE);
      r_load       <= (w_state_nxt == LOAD);
      r_busy       <= (w_state_nxt != IDLE);
      r_sgd        <= w_sgd_nxt;
      r_ovf        <= w_ovf_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_op    <= w_pend_op_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign bus.sel      = r_sel;
  assign bus.add_sub  = r_add_sub;
  assign bus.enter    = r_enter;
  assign bus.load     = r_load;
  assign bus.busy     = r_busy;
  assign bus.sgd      = r_sgd;
  assign bus.overflow = r_ovf;
  // Timeout marks the last WAIT cycle itself, so it is decoded from state,
  // counter and the same-cycle mult_done rather than registered.
  assign bus.timeout  = w_timeout;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed self-checking bench for calc_op_sequencer (TIMEOUT_CYCLES = 8).
// Outputs are packed as {sel[1:0], enter, add_sub, sgd, load, busy, timeout, overflow}.
module tb_calc_op_sequencer;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_bad = 0;

  calc_op_sequencer_if bus ();

  calc_op_sequencer #(
    .TIMEOUT_CYCLES (TO),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {bus.sel, bus.enter, bus.add_sub, bus.sgd, bus.load, bus.busy,
            bus.timeout, bus.overflow};
  endfunction

  // Advance n clock edges; drive and sample 2 time units after each edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.btn_add   = 1'b0;
    bus.btn_sub   = 1'b0;
    bus.btn_mult  = 1'b0;
    bus.btn_sqr   = 1'b0;
    bus.btn_sgd   = 1'b0;
    bus.mult_done = 1'b0;
    #3;
    check("reset_outs", 32'(outs()), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    check("post_reset_idle", 32'(outs()), 32'h0);

    // ADD: pulse at edge 2, ISSUE after edge 3, LOAD after edge 4.
    bus.btn_add = 1'b1;
    cyc(2);
    check("add_pulse_not_busy", 32'(bus.busy), 32'h0);
    cyc(1);
    check("add_issue", 32'(outs()), 32'(9'b00_1000100));
    cyc(1);
    check("add_load", 32'(outs()), 32'(9'b00_0001100));
    bus.btn_add = 1'b0;
    cyc(1);
    check("add_idle", 32'(outs()), 32'(9'b00_0000000));

    // MULT with mult_done: enter in ISSUE, sel held through LOAD.
    bus.btn_mult = 1'b1;
    cyc(3);
    check("mult_issue", 32'(outs()), 32'(9'b10_1000100));
    bus.btn_mult = 1'b0;
    cyc(1);
    check("mult_wait", 32'(outs()), 32'(9'b10_0000100));
    cyc(2);
    check("mult_wait_hold", 32'(outs()), 32'(9'b10_0000100));
    bus.mult_done = 1'b1;
    cyc(1);
    check("mult_load", 32'(outs()), 32'(9'b10_0001100));
    bus.mult_done = 1'b0;
    cyc(1);
    check("mult_idle", 32'(outs()), 32'(9'b10_0000000));

    // SQR without mult_done: timeout on the 8th WAIT cycle, no load.
    bus.btn_sqr = 1'b1;
    cyc(3);
    check("sqr_issue", 32'(outs()), 32'(9'b11_1000100));
    bus.btn_sqr = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      cyc(1);
      check("sqr_wait", 32'(outs()), 32'(9'b11_0000100));
    end
    cyc(1);
    check("sqr_timeout", 32'(outs()), 32'(9'b11_0000110));
    cyc(1);
    check("sqr_timeout_idle", 32'(outs()), 32'(9'b11_0000000));

    // SUB+MULT together, SQR while busy (pending), ADD into freed pending,
    // then SUB while pending full (dropped).
    bus.btn_sub  = 1'b1;
    bus.btn_mult = 1'b1;
    cyc(1);
    bus.btn_sqr = 1'b1;
    cyc(2);
    check("sub_issue_ovf", 32'(outs()), 32'(9'b01_1100101));
    cyc(1);
    check("sub_load", 32'(outs()), 32'(9'b01_0101100));
    cyc(1);
    check("pend_sqr_issue", 32'(outs()), 32'(9'b11_1000100));
    bus.btn_sub  = 1'b0;
    bus.btn_mult = 1'b0;
    bus.btn_sqr  = 1'b0;
    cyc(1);
    check("pend_sqr_wait", 32'(outs()), 32'(9'b11_0000100));
    bus.btn_add = 1'b1;
    cyc(1);
    bus.btn_sub = 1'b1;
    cyc(2);
    check("add_to_pending", 32'(outs()), 32'(9'b11_0000100));
    cyc(1);
    check("sub_dropped_ovf", 32'(outs()), 32'(9'b11_0000101));
    bus.mult_done = 1'b1;
    cyc(1);
    check("pend_sqr_load", 32'(outs()), 32'(9'b11_0001100));
    bus.mult_done = 1'b0;
    bus.btn_add   = 1'b0;
    bus.btn_sub   = 1'b0;
    cyc(1);
    check("pend_add_issue", 32'(outs()), 32'(9'b00_1000100));
    cyc(1);
    check("pend_add_load", 32'(outs()), 32'(9'b00_0001100));
    cyc(1);
    check("pend_drained_idle", 32'(outs()), 32'(9'b00_0000000));

    // Sign toggle in IDLE, then dropped while in WAIT.
    bus.btn_sgd = 1'b1;
    cyc(3);
    check("sgd_toggle", 32'(outs()), 32'(9'b00_0010000));
    bus.btn_sgd  = 1'b0;
    bus.btn_mult = 1'b1;
    cyc(3);
    check("sgd_mult_issue", 32'(outs()), 32'(9'b10_1010100));
    bus.btn_mult = 1'b0;
    cyc(1);
    bus.btn_sgd = 1'b1;
    cyc(3);
    check("sgd_busy_ovf", 32'(outs()), 32'(9'b10_0010101));
    cyc(1);
    check("sgd_busy_hold", 32'(outs()), 32'(9'b10_0010100));
    bus.btn_sgd   = 1'b0;
    bus.mult_done = 1'b1;
    cyc(1);
    check("sgd_mult_load", 32'(outs()), 32'(9'b10_0011100));
    bus.mult_done = 1'b0;
    cyc(1);
    check("sgd_mult_idle", 32'(outs()), 32'(9'b10_0010000));

    // Asynchronous reset during WAIT with pending full, then stray mult_done.
    bus.btn_mult = 1'b1;
    cyc(3);
    check("rst_mult_issue", 32'(bus.enter), 32'h1);
    bus.btn_mult = 1'b0;
    bus.btn_sqr  = 1'b1;
    cyc(4);
    check("rst_pre_wait", 32'(outs()), 32'(9'b10_0010100));
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", 32'(outs()), 32'h0);
    bus.btn_sqr   = 1'b0;
    bus.mult_done = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("rst_stray_done", 32'(outs()), 32'h0);
    end
    bus.mult_done = 1'b0;
    cyc(2);
    check("rst_pending_cleared", 32'(outs()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
